// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths, NOP encoding and fetch state type for the CPU core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;

   localparam logic [15:0] NOP = 16'h0000;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_REQ   = 2'd1,
      FETCH_HOLD  = 2'd2,
      FETCH_DRAIN = 2'd3
   } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module : if_id_reg
// Brief  : IF/ID pipeline register with flush (priority), load and hold.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_reg
   import cpu_pkg::*;
#(
   parameter int PC_W    = cpu_pkg::PC_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               rest,
   input  logic               i_load,
   input  logic               i_flush,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [PC_W-1:0]    i_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_pc,
   output logic               o_valid
);

   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               valid_q, valid_d;

   // A flush turns the slot into a bubble but leaves the PC field untouched.
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (i_flush) begin
         instr_d = INSTR_W'(NOP);
         valid_d = 1'b0;
      end else if (i_load) begin
         instr_d = i_instr;
         pc_d    = i_pc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign o_instr = instr_q;
   assign o_pc    = pc_q;
   assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch FSM, PC and skid buffer feeding the IF/ID register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import cpu_pkg::*;
#(
   parameter int PC_W    = cpu_pkg::PC_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               rest,
   input  logic               FrezePC,
   input  logic               FrezeIFID,
   input  logic               Branch,
   input  logic [PC_W-1:0]    BranchTarget,
   input  logic               Jump,
   input  logic [PC_W-1:0]    JumpTarget,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] IFID_Instr,
   output logic [PC_W-1:0]    IFID_PC,
   output logic               IFID_Valid,
   output logic [3:0]         IFID_Rs,
   output logic [3:0]         IFID_Rt
);

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] skid_q, skid_d;

   logic               stall;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic [PC_W-1:0]    pc_inc;
   logic               ifid_load;
   logic               ifid_flush;
   logic [INSTR_W-1:0] ifid_instr_in;

   assign stall       = FrezePC | FrezeIFID;
   assign redirect    = Branch | Jump;
   assign redirect_pc = Jump ? JumpTarget : BranchTarget;
   assign pc_inc      = pc_q + PC_W'(1);

   // imem_req is a pure function of state, keeping rdata out of its cone.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      skid_d        = skid_q;
      imem_req      = 1'b0;
      ifid_load     = 1'b0;
      ifid_flush    = 1'b0;
      ifid_instr_in = skid_q;

      case (state_q)
         FETCH_IDLE: begin
            state_d = FETCH_REQ;
            if (redirect) begin
               pc_d       = redirect_pc;
               ifid_flush = 1'b1;
               skid_d     = '0;
            end
         end

         FETCH_REQ: begin
            imem_req = 1'b1;
            if (redirect) begin
               pc_d       = redirect_pc;
               ifid_flush = 1'b1;
               skid_d     = '0;
               state_d    = imem_ack ? FETCH_REQ : FETCH_DRAIN;
            end else if (imem_ack) begin
               if (stall) begin
                  skid_d  = imem_rdata;
                  state_d = FETCH_HOLD;
               end else begin
                  ifid_load     = 1'b1;
                  ifid_instr_in = imem_rdata;
                  pc_d          = pc_inc;
               end
            end else if (!stall) begin
               ifid_flush = 1'b1;
            end
         end

         FETCH_HOLD: begin
            if (redirect) begin
               pc_d       = redirect_pc;
               ifid_flush = 1'b1;
               skid_d     = '0;
               state_d    = FETCH_REQ;
            end else if (!stall) begin
               ifid_load = 1'b1;
               pc_d      = pc_inc;
               state_d   = FETCH_REQ;
            end
         end

         FETCH_DRAIN: begin
            // The in-flight response belongs to the old path and is dropped.
            if (redirect) begin
               pc_d = redirect_pc;
            end
            if (imem_ack) begin
               state_d = FETCH_REQ;
            end
         end

         default: state_d = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_q <= FETCH_IDLE;
         pc_q    <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         skid_q  <= skid_d;
      end
   end

   assign imem_addr = pc_q;

   if_id_reg #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_if_id_reg (
      .clk     (clk),
      .rest    (rest),
      .i_load  (ifid_load),
      .i_flush (ifid_flush),
      .i_instr (ifid_instr_in),
      .i_pc    (pc_inc),
      .o_instr (IFID_Instr),
      .o_pc    (IFID_PC),
      .o_valid (IFID_Valid)
   );

   assign IFID_Rs = IFID_Instr[7:4];
   assign IFID_Rt = IFID_Instr[3:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Directed self-checking bench for fetch_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rest;
   logic        FrezePC, FrezeIFID;
   logic        Branch, Jump;
   logic [15:0] BranchTarget, JumpTarget;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] IFID_Instr;
   logic [15:0] IFID_PC;
   logic        IFID_Valid;
   logic [3:0]  IFID_Rs, IFID_Rt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_unit #(.PC_W(16), .INSTR_W(16)) dut (
      .clk          (clk),
      .rest         (rest),
      .FrezePC      (FrezePC),
      .FrezeIFID    (FrezeIFID),
      .Branch       (Branch),
      .BranchTarget (BranchTarget),
      .Jump         (Jump),
      .JumpTarget   (JumpTarget),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .IFID_Instr   (IFID_Instr),
      .IFID_PC      (IFID_PC),
      .IFID_Valid   (IFID_Valid),
      .IFID_Rs      (IFID_Rs),
      .IFID_Rt      (IFID_Rt)
   );

   // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rest = 1'b0; FrezePC = 0; FrezeIFID = 0; Branch = 0; Jump = 0;
      BranchTarget = 16'h0; JumpTarget = 16'h0; imem_ack = 0; imem_rdata = 16'h0;
      step(); step(); step();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req actual=%h expected=0", imem_req); end
      checks++; if (imem_addr !== 16'h0) begin failures++; $display("FAIL rst_addr actual=%h expected=0000", imem_addr); end
      checks++; if (IFID_Instr !== 16'h0) begin failures++; $display("FAIL rst_instr actual=%h expected=0000", IFID_Instr); end
      checks++; if (IFID_PC !== 16'h0) begin failures++; $display("FAIL rst_ifid_pc actual=%h expected=0000", IFID_PC); end
      checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%h expected=0", IFID_Valid); end
      rest = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req actual=%h expected=0", imem_req); end
      step();
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req actual=%h expected=1", imem_req); end
      checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL first_addr actual=%h expected=0000", imem_addr); end
   endtask

   task automatic test_stream();
      imem_ack = 1; imem_rdata = 16'h1234;
      step();
      checks++; if (IFID_PC !== 16'h0001) begin failures++; $display("FAIL stream_pc0 actual=%h expected=0001", IFID_PC); end
      checks++; if (IFID_Instr !== 16'h1234) begin failures++; $display("FAIL stream_instr0 actual=%h expected=1234", IFID_Instr); end
      checks++; if (IFID_Valid !== 1'b1) begin failures++; $display("FAIL stream_valid0 actual=%h expected=1", IFID_Valid); end
      checks++; if (IFID_Rs !== 4'h3 || IFID_Rt !== 4'h4) begin failures++; $display("FAIL stream_rs_rt actual=%h/%h expected=3/4", IFID_Rs, IFID_Rt); end
      checks++; if (imem_addr !== 16'h0001) begin failures++; $display("FAIL stream_addr1 actual=%h expected=0001", imem_addr); end
      imem_rdata = 16'hABCD;
      step();
      checks++; if (IFID_PC !== 16'h0002 || IFID_Instr !== 16'hABCD) begin failures++; $display("FAIL stream_second actual=%h/%h expected=0002/abcd", IFID_PC, IFID_Instr); end
      checks++; if (imem_addr !== 16'h0002) begin failures++; $display("FAIL stream_addr2 actual=%h expected=0002", imem_addr); end
      imem_ack = 0;
      step();
      checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 16'h0000) begin failures++; $display("FAIL bubble actual=%h/%h expected=0/0000", IFID_Valid, IFID_Instr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin failures++; $display("FAIL addr_stable actual=%h/%h expected=1/0002", imem_req, imem_addr); end
   endtask

   task automatic test_stall_hold();
      FrezePC = 1; FrezeIFID = 1; imem_ack = 1; imem_rdata = 16'h5678;
      step();
      imem_ack = 0;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req actual=%h expected=0", imem_req); end
      checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 16'h0000) begin failures++; $display("FAIL hold_ifid actual=%h/%h expected=0/0000", IFID_Valid, IFID_Instr); end
      checks++; if (imem_addr !== 16'h0002) begin failures++; $display("FAIL hold_pc actual=%h expected=0002", imem_addr); end
      step(); step();
      checks++; if (imem_req !== 1'b0 || IFID_Valid !== 1'b0) begin failures++; $display("FAIL hold_3rd actual=%h/%h expected=0/0", imem_req, IFID_Valid); end
      FrezePC = 0; FrezeIFID = 0;
      step();
      checks++; if (IFID_Instr !== 16'h5678 || IFID_Valid !== 1'b1) begin failures++; $display("FAIL unhold_instr actual=%h/%h expected=5678/1", IFID_Instr, IFID_Valid); end
      checks++; if (IFID_PC !== 16'h0003) begin failures++; $display("FAIL unhold_pc actual=%h expected=0003", IFID_PC); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0003) begin failures++; $display("FAIL unhold_addr actual=%h/%h expected=1/0003", imem_req, imem_addr); end
   endtask

   task automatic test_stall_noack();
      FrezeIFID = 1;
      step();
      checks++; if (IFID_Instr !== 16'h5678 || IFID_Valid !== 1'b1) begin failures++; $display("FAIL stall_keep actual=%h/%h expected=5678/1", IFID_Instr, IFID_Valid); end
      checks++; if (imem_addr !== 16'h0003) begin failures++; $display("FAIL stall_pc actual=%h expected=0003", imem_addr); end
   endtask

   task automatic test_jump_drain();
      Jump = 1; JumpTarget = 16'h0040;
      step();
      Jump = 0; FrezeIFID = 0;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL drain_req actual=%h expected=0", imem_req); end
      checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 16'h0000) begin failures++; $display("FAIL drain_flush actual=%h/%h expected=0/0000", IFID_Valid, IFID_Instr); end
      step();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL drain_wait actual=%h expected=0", imem_req); end
      imem_ack = 1; imem_rdata = 16'hDEAD;
      step();
      imem_ack = 0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin failures++; $display("FAIL drain_target actual=%h/%h expected=1/0040", imem_req, imem_addr); end
      checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 16'h0000) begin failures++; $display("FAIL drain_discard actual=%h/%h expected=0/0000", IFID_Valid, IFID_Instr); end
   endtask

   task automatic test_both_redirect();
      Branch = 1; BranchTarget = 16'h0010; Jump = 1; JumpTarget = 16'h0020; imem_ack = 1; imem_rdata = 16'hBEEF;
      step();
      Branch = 0; Jump = 0; imem_ack = 0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin failures++; $display("FAIL jump_wins actual=%h/%h expected=1/0020", imem_req, imem_addr); end
      checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("FAIL redirect_ack_discard actual=%h expected=0", IFID_Valid); end
   endtask

   task automatic test_wrap();
      Jump = 1; JumpTarget = 16'hFFFF; imem_ack = 1; imem_rdata = 16'h1111;
      step();
      Jump = 0; imem_rdata = 16'h0F0F;
      checks++; if (imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup actual=%h expected=ffff", imem_addr); end
      step();
      checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr actual=%h expected=0000", imem_addr); end
      checks++; if (IFID_PC !== 16'h0000 || IFID_Instr !== 16'h0F0F) begin failures++; $display("FAIL wrap_ifid actual=%h/%h expected=0000/0f0f", IFID_PC, IFID_Instr); end
   endtask

   task automatic test_reset_mid();
      imem_rdata = 16'h7777;
      step();
      imem_ack = 0; FrezeIFID = 1;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001 || IFID_Valid !== 1'b1) begin failures++; $display("FAIL mid_setup actual=%h/%h/%h expected=1/0001/1", imem_req, imem_addr, IFID_Valid); end
      #2 rest = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin failures++; $display("FAIL mid_rst_req actual=%h/%h expected=0/0000", imem_req, imem_addr); end
      checks++; if (IFID_Instr !== 16'h0000 || IFID_PC !== 16'h0000 || IFID_Valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ifid actual=%h/%h/%h expected=0000/0000/0", IFID_Instr, IFID_PC, IFID_Valid); end
      FrezeIFID = 0;
      step();
      rest = 1'b1;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL restart actual=%h/%h expected=1/0000", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_hold();
      test_stall_noack();
      test_jump_drain();
      test_both_redirect();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, PC and instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width; fields opcode[15:12], Rd[11:8], Rs[7:4], Rt[3:0].
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rest  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port FrezePC  in  1  stall request from hazard detection.
REQ-006 SHALL have port FrezeIFID  in  1  stall request from hazard detection.
REQ-007 SHALL have port Branch  in  1  branch taken, resolved in ID.
REQ-008 SHALL have port BranchTarget  in  PC_W  branch destination.
REQ-009 SHALL have port Jump  in  1  jump taken.
REQ-010 SHALL have port JumpTarget  in  PC_W  jump destination.
REQ-011 SHALL have port imem_req  out  1  instruction-memory request.
REQ-012 SHALL have port imem_addr  out  PC_W  request address.
REQ-013 SHALL have port imem_ack  in  1  data valid, completes request.
REQ-014 SHALL have port imem_rdata  in  INSTR_W  fetched instruction.
REQ-015 SHALL have port IFID_Instr  out  INSTR_W  IF/ID instruction.
REQ-016 SHALL have port IFID_PC  out  PC_W  IF/ID PC+1 of held instruction.
REQ-017 SHALL have port IFID_Valid  out  1  IF/ID holds a real instruction.
REQ-018 SHALL have port IFID_Rs  out  4  IFID_Instr[7:4], combinational.
REQ-019 SHALL have port IFID_Rt  out  4  IFID_Instr[3:0], combinational.

Function
REQ-020 SHALL define stall = FrezePC | FrezeIFID and redirect = Branch | Jump; Jump target SHALL win when both are high.
REQ-021 SHALL implement FSM states IDLE, REQ, HOLD, DRAIN.
REQ-022 In IDLE: imem_req=0; next state REQ unconditionally.
REQ-023 In REQ: imem_req=1 and imem_addr=PC; imem_addr SHALL stay stable until imem_ack.
REQ-024 In REQ, ack, no stall, no redirect: load IF/ID with rdata, PC+1, Valid=1; PC<=PC+1; stay REQ.
REQ-025 In REQ, ack while stalled: capture rdata in skid buffer; IF/ID and PC unchanged; go to HOLD.
REQ-026 In REQ, no ack, no redirect: IF/ID SHALL hold if stalled; otherwise IFID_Valid<=0 and IFID_Instr<=0x0000 (NOP).
REQ-027 In HOLD: imem_req=0; when stall drops, load IF/ID from buffer, PC<=PC+1, go to REQ.
REQ-028 Redirect in any state SHALL override stall: PC<=target, IFID_Valid<=0, IFID_Instr<=0x0000, skid buffer discarded.
REQ-029 Redirect in REQ without ack: go to DRAIN; imem_req drops that cycle.
REQ-030 Redirect in REQ with ack: discard data, stay REQ at target next cycle.
REQ-031 In DRAIN: imem_req=0; wait for imem_ack of the outstanding request, discard data, go to REQ.
REQ-032 A redirect arriving while in DRAIN SHALL update PC only.
REQ-033 PC+1 SHALL wrap modulo 2^PC_W (0xFFFF -> 0x0000).
REQ-034 The module SHALL have no combinational path from imem_rdata to imem_req.

Reset
REQ-035 While rest=0: state IDLE, PC=0, imem_req=0, IFID_Instr=0, IFID_PC=0, IFID_Valid=0, skid buffer=0.
REQ-036 Reset mid-transaction SHALL abandon the outstanding request.
REQ-037 First request SHALL issue address 0x0000 two cycles after rest rises.

Structure
REQ-038 Shared package cpu_pkg SHALL hold PC_W, INSTR_W, NOP encoding 0x0000, and the fetch state enum.
REQ-039 IF/ID register (load, flush, hold) SHALL be sub-module if_id_reg; FSM and PC stay in fetch_unit.

Verification
REQ-040 Scenario: release reset, imem_ack every cycle, rdata=0x1234 -> addr 0,1,2...; IFID_PC=1 with IFID_Instr=0x1234, Valid=1.
REQ-041 Scenario: FrezePC=FrezeIFID=1 for 3 cycles at the ack cycle -> HOLD; IF/ID unchanged; then buffered instruction loads and PC advances by exactly 1.
REQ-042 Scenario: Jump=1, JumpTarget=0x0040 with no ack pending -> DRAIN; late ack data discarded; next request addr=0x0040; IFID_Valid=0.
REQ-043 Scenario: Branch=1 and Jump=1 simultaneously, targets 0x0010 and 0x0020 -> next addr 0x0020.
REQ-044 Scenario: PC=0xFFFF with ack -> next addr 0x0000, IFID_PC=0x0000.
REQ-045 Scenario: rest=0 while waiting for ack -> all outputs at reset values immediately; after release, fetch restarts at 0x0000.
